// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared types and constants for the multiply/divide unit
// Contents: default widths, ROB tag type, funct3 op enum, FSM state encoding.
package mul_div_unit_pkg;

  localparam int MDU_XLEN      = 32;
  localparam int MDU_ROB_IDX_W = 5;

  typedef logic [MDU_ROB_IDX_W-1:0] rob_idx_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mul_div_op_t;

  typedef logic [1:0] mul_div_state_t;

  localparam mul_div_state_t S_IDLE = 2'd0;
  localparam mul_div_state_t S_MUL  = 2'd1;
  localparam mul_div_state_t S_DIV  = 2'd2;
  localparam mul_div_state_t S_DONE = 2'd3;

endpackage

// File: rtl/mul_div_divider.sv
// mul_div_divider: iterative restoring radix-2 divider on unsigned magnitudes
// Ports: clk_i/rst_i (sync, active-high), start_i loads operands, done_o is
// high for one cycle once quo_o/rem_o hold the XLEN-step result.
module mul_div_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  localparam int CW = $clog2(XLEN + 1);

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, div_q;
  logic [XLEN:0]   r_sh, diff;

  // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
  assign r_sh   = {rem_q, quo_q[XLEN-1]};
  assign diff   = r_sh - {1'b0, div_q};
  assign done_o = busy_q & (cnt_q == CW'(XLEN));
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend_i;
      rem_q  <= '0;
      div_q  <= divisor_i;
    end else if (done_o) begin
      busy_q <= 1'b0;
    end else if (busy_q) begin
      cnt_q  <= cnt_q + 1'b1;
      rem_q  <= diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
      quo_q  <= {quo_q[XLEN-2:0], ~diff[XLEN]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle RV M-extension multiply/divide unit on issue port 0
// Ports: i_clk, i_rst (sync active-high), i_flush (same effect as reset);
// issue side i_valid/i_op/i_src1/i_src2/i_rd/i_rob_idx with o_ready;
// writeback side o_wb_valid/o_wb_rd/o_wb_rob_idx/o_wb_data with i_wb_ready.
// Optional macro MUL_DIV_UNIT_EARLY_OUT_EN: trivial divides finish in 1 cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN        = MDU_XLEN,
  parameter int ROB_IDX_W   = MDU_ROB_IDX_W,
  parameter int MUL_LATENCY = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [2:0]           i_op,
  input  logic [XLEN-1:0]      i_src1,
  input  logic [XLEN-1:0]      i_src2,
  input  logic [4:0]           i_rd,
  input  logic [ROB_IDX_W-1:0] i_rob_idx,
  output logic                 o_ready,
  output logic                 o_wb_valid,
  output logic [4:0]           o_wb_rd,
  output logic [ROB_IDX_W-1:0] o_wb_rob_idx,
  output logic [XLEN-1:0]      o_wb_data,
  input  logic                 i_wb_ready
);

  logic                   rst, accept, div_start, div_done, early;
  logic                   in_sgn, q_neg_in, r_neg_in;
  logic                   fix_q, fix_d, q_neg_q, r_neg_q;
  mul_div_state_t         state_q, state_d;
  mul_div_op_t            op_q;
  logic [XLEN-1:0]        data_q, data_d, a_mag, b_mag, quo, rem;
  logic [XLEN-1:0]        mul_res, div_res, early_res;
  logic [4:0]             rd_q;
  logic [ROB_IDX_W-1:0]   rob_q;
  logic [2*XLEN-1:0]      mul_a, mul_b, prod_d, prod_q;
  logic [MUL_LATENCY-1:0] pipe_q, pipe_d;

  assign rst    = i_rst | i_flush;
  assign accept = i_valid & (state_q == S_IDLE);

  // Signed divide ops (DIV/REM) have funct3 bit 0 clear
  assign in_sgn   = ~i_op[0];
  assign a_mag    = (in_sgn & i_src1[XLEN-1]) ? -i_src1 : i_src1;
  assign b_mag    = (in_sgn & i_src2[XLEN-1]) ? -i_src2 : i_src2;
  // A zero divisor keeps the all-ones quotient unnegated
  assign q_neg_in = in_sgn & (i_src1[XLEN-1] ^ i_src2[XLEN-1]) & (|i_src2);
  assign r_neg_in = in_sgn & i_src1[XLEN-1];

  // src1 is signed for MUL/MULH/MULHSU, src2 only for MUL/MULH; the low 2*XLEN
  // bits of the extended product are exact for every sign combination
  assign mul_a  = {{XLEN{(i_op != 3'd3) & i_src1[XLEN-1]}}, i_src1};
  assign mul_b  = {{XLEN{~i_op[1] & i_src2[XLEN-1]}}, i_src2};
  assign prod_d = mul_a * mul_b;

  assign mul_res = (op_q == OP_MUL) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
  assign div_res = op_q[1] ? (r_neg_q ? -rem : rem) : (q_neg_q ? -quo : quo);

`ifdef MUL_DIV_UNIT_EARLY_OUT_EN
  logic div0, ovf;
  assign div0      = ~|i_src2;
  assign ovf       = in_sgn & (i_src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_src2);
  assign early     = i_op[2] & (div0 | ovf | (b_mag > a_mag));
  assign early_res = i_op[1] ? (ovf ? '0 : i_src1)
                   : div0 ? '1 : ovf ? {1'b1, {(XLEN-1){1'b0}}} : '0;
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  assign div_start = accept & i_op[2] & ~early;

  mul_div_divider #(.XLEN(XLEN)) u_div (
    .clk_i      (i_clk),
    .rst_i      (rst),
    .start_i    (div_start),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .done_o     (div_done),
    .quo_o      (quo),
    .rem_o      (rem)
  );

  // An early-out divide spends one cycle in DIV with fix_q already set, so its
  // result lands in DONE one cycle after accept; a full divide sets fix_q on the
  // divider's done pulse and uses that cycle for the sign fix-up
  always_comb begin
    state_d = (state_q == S_IDLE) ? (accept ? (i_op[2] ? S_DIV : S_MUL) : S_IDLE)
            : (state_q == S_MUL)  ? (pipe_q[MUL_LATENCY-1] ? S_DONE : S_MUL)
            : (state_q == S_DIV)  ? (fix_q ? S_DONE : S_DIV)
            : (i_wb_ready ? S_IDLE : S_DONE);
    data_d  = (accept & early) ? early_res
            : (state_q == S_MUL & pipe_q[MUL_LATENCY-1]) ? mul_res
            : (state_q == S_DIV & div_done) ? div_res
            : data_q;
    fix_d   = (accept & early) | (state_q == S_DIV & div_done);
    pipe_d  = accept ? (i_op[2] ? '0 : MUL_LATENCY'(1)) : pipe_q << 1;
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      fix_q   <= 1'b0;
      pipe_q  <= '0;
      op_q    <= OP_MUL;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      prod_q  <= '0;
      rd_q    <= '0;
      rob_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      fix_q   <= fix_d;
      pipe_q  <= pipe_d;
      if (accept) begin
        op_q    <= mul_div_op_t'(i_op);
        q_neg_q <= q_neg_in;
        r_neg_q <= r_neg_in;
        prod_q  <= prod_d;
        rd_q    <= i_rd;
        rob_q   <= i_rob_idx;
      end
    end
  end

  assign o_ready      = state_q == S_IDLE;
  assign o_wb_valid   = state_q == S_DONE;
  assign o_wb_rd      = rd_q;
  assign o_wb_rob_idx = rob_q;
  assign o_wb_data    = data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit with directed vectors
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int ML = 3;
  localparam int DL = 34;
`ifdef MUL_DIV_UNIT_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 34;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, valid, wb_ready;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic [4:0]  rd;
  rob_idx_t    rob;
  logic        o_ready, o_wb_valid;
  logic [4:0]  o_wb_rd;
  rob_idx_t    o_wb_rob_idx;
  logic [31:0] o_wb_data;

  mul_div_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .i_valid      (valid),
    .i_op         (op),
    .i_src1       (src1),
    .i_src2       (src2),
    .i_rd         (rd),
    .i_rob_idx    (rob),
    .o_ready      (o_ready),
    .o_wb_valid   (o_wb_valid),
    .o_wb_rd      (o_wb_rd),
    .o_wb_rob_idx (o_wb_rob_idx),
    .o_wb_data    (o_wb_data),
    .i_wb_ready   (wb_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    rob_idx_t    rob;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int errors = 0, checks = 0, issued = 0, retired = 0, tags = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per writeback handshake
  int          first_cyc = -1;
  logic [31:0] held_data;
  exp_t        m;
  always @(negedge clk) begin
    if (o_wb_valid === 1'b1) begin
      check("ready_low_in_done", {31'd0, o_ready}, 32'd0);
      if (first_cyc < 0) first_cyc = cyc;
      else check("wb_data_stable", o_wb_data, held_data);
      held_data = o_wb_data;
      if (wb_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: got data %h rd %0d, expected no writeback", o_wb_data, o_wb_rd);
        end else begin
          m = sb.pop_front();
          check({m.name, "_data"}, o_wb_data, m.data);
          check({m.name, "_rd"}, {27'd0, o_wb_rd}, {27'd0, m.rd});
          check({m.name, "_rob"}, {27'd0, o_wb_rob_idx}, {27'd0, m.rob});
          check({m.name, "_lat"}, 32'(first_cyc - m.acc), 32'(m.lat));
          retired++;
        end
        first_cyc = -1;
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a, b, exp,
                       input int lat, input bit hold, input bit push);
    int n = 0;
    exp_t e;
    tags++;
    op = f; src1 = a; src2 = b; rd = 5'(tags); rob = rob_idx_t'(tags * 3); valid = 1'b1;
    while (o_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_issue: o_ready stuck at %b, required 1 within 200 cycles", name, o_ready);
      valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    check({name, "_busy"}, {31'd0, o_ready}, 32'd0);
    if (push) begin
      e.data = exp; e.rd = rd; e.rob = rob; e.acc = cyc; e.lat = lat; e.name = name;
      sb.push_back(e);
      issued++;
    end
    if (!hold) valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish before 30000 cycles");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; valid = 1'b0; wb_ready = 1'b1;
    op = '0; src1 = '0; src2 = '0; rd = '0; rob = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
    check("rst_rd", {27'd0, o_wb_rd}, 32'd0);
    check("rst_rob", {27'd0, o_wb_rob_idx}, 32'd0);
    check("rst_data", o_wb_data, 32'd0);
    rst = 1'b0;

    issue("mulhu_ones", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML, 0, 1);
    issue("mul_ones", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, ML, 0, 1);
    issue("mulh_ones", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, ML, 0, 1);
    issue("mulhsu_ones", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ML, 0, 1);
    issue("mul_7x6", 3'd0, 32'd7, 32'd6, 32'd42, ML, 0, 1);
    issue("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, ML, 0, 1);
    issue("mulhsu_min", 3'd2, 32'h80000000, 32'd2, 32'hFFFFFFFF, ML, 0, 1);
    issue("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DL, 0, 1);
    issue("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DL, 0, 1);
    issue("divu_5_0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, EL, 0, 1);
    issue("remu_5_0", 3'd7, 32'd5, 32'd0, 32'd5, EL, 0, 1);
    issue("div_m5_0", 3'd4, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, EL, 0, 1);
    issue("rem_m5_0", 3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, EL, 0, 1);
    issue("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, EL, 0, 1);
    issue("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, EL, 0, 1);
    issue("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, DL, 0, 1);
    issue("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, DL, 0, 1);
    issue("div_7_m2", 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, DL, 0, 1);
    issue("rem_7_m2", 3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, DL, 0, 1);
    issue("divu_3_10", 3'd5, 32'd3, 32'd10, 32'd0, EL, 0, 1);
    issue("rem_3_m10", 3'd6, 32'd3, 32'hFFFFFFF6, 32'd3, EL, 0, 1);
    drain();

    issue("div_flushed", 3'd5, 32'd100, 32'd7, 32'd14, DL, 0, 0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", {31'd0, o_ready}, 32'd1);
    check("flush_wb_valid", {31'd0, o_wb_valid}, 32'd0);
    issue("mul_after_flush", 3'd0, 32'd9, 32'd9, 32'd81, ML, 0, 1);
    repeat (40) @(posedge clk);
    #1;
    drain();

    wb_ready = 1'b0;
    issue("mul_bp", 3'd0, 32'd3, 32'd5, 32'd15, ML, 0, 1);
    n = 0;
    while (o_wb_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", {31'd0, o_wb_valid}, 32'd1);
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", {31'd0, o_ready}, 32'd1);
    check("bp_release_valid", {31'd0, o_wb_valid}, 32'd0);

    issue("b2b_mul", 3'd0, 32'd11, 32'd3, 32'd33, ML, 1, 1);
    issue("b2b_div", 3'd5, 32'd50, 32'd7, 32'd7, DL, 1, 1);
    issue("b2b_mulhu", 3'd3, 32'h80000000, 32'd4, 32'd2, ML, 1, 1);
    issue("b2b_remu", 3'd7, 32'd50, 32'd7, 32'd1, DL, 0, 1);
    drain();
    check("retired_count", 32'(retired), 32'(issued));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle integer multiply/divide functional unit (RV M-extension funct3 ops) on issue port 0, directly downstream of the instruction scheduler.
- Accepts one issued MUL-unit instruction with its operands, computes the result with a fixed-latency multiplier or a radix-2 iterative divider, then presents a writeback with ROB index and rd.
- Drives the scheduler's mul-ready input.

Parameters:
- XLEN, 32, operand/result width
- ROB_IDX_W, 5, width of ROB index tag
- MUL_LATENCY, 3, cycles from accept to writeback-valid for multiply ops (>=1)

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_flush  input  1  pipeline flush; aborts in-flight op
- i_valid  input  1  issued instruction targets this unit
- i_op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_src1  input  XLEN  rs1 value
- i_src2  input  XLEN  rs2 value
- i_rd  input  5  destination arch reg
- i_rob_idx  input  ROB_IDX_W  ROB tag
- o_ready  output  1  unit idle, may accept (feeds scheduler mul-ready)
- o_wb_valid  output  1  result available
- o_wb_rd  output  5  destination reg
- o_wb_rob_idx  output  ROB_IDX_W  ROB tag
- o_wb_data  output  XLEN  result
- i_wb_ready  input  1  writeback arbiter accepts result this cycle

Behaviour:
- One clock (i_clk); reset synchronous, active-high (i_rst); i_flush has identical effect to reset.
- Reset/flush: state IDLE, o_ready=1, o_wb_valid=0, o_wb_rd=0, o_wb_rob_idx=0, o_wb_data=0, counters 0.
- Accept: i_valid & o_ready at a rising edge latches op, operands, rd, rob_idx. i_valid while o_ready=0 is a scheduler error and is ignored.
- FSM states and transitions:
  - IDLE: o_ready=1. On accept, go to MUL if op<4, else DIV.
  - MUL: full 2*XLEN product of sign/zero-extended operands (MULHSU: src1 signed, src2 unsigned). After MUL_LATENCY-1 cycles in MUL, go to DONE; o_wb_valid asserts exactly MUL_LATENCY cycles after accept. MUL selects the low XLEN bits; the other ops select the high XLEN bits.
  - DIV: restoring radix-2 on operand magnitudes, one quotient bit per cycle, XLEN cycles, then sign fix-up cycle, then DONE. o_wb_valid asserts XLEN+2 cycles after accept.
  - DONE: o_wb_valid=1, outputs stable. If i_wb_ready, go to IDLE next cycle. o_ready stays 0 in DONE; no accept in the same cycle as wb handshake.
- Divide semantics:
  - Quotient sign = sign(src1) XOR sign(src2); remainder sign = sign(src1).
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give src1.
  - Signed overflow (src1=min, src2=-1): DIV gives min, REM gives 0.
- Flush/reset in any state abandons the op with no writeback; o_wb_valid falls next cycle.
- Backpressure: DONE is held indefinitely while i_wb_ready=0; data must not change.

Optional Feature:
- MUL_DIV_UNIT_EARLY_OUT_EN defined: divide-by-zero and signed-overflow cases go IDLE->DONE directly, o_wb_valid 1 cycle after accept. Divides whose src2 magnitude exceeds src1 magnitude also finish in 1 cycle (quotient 0, remainder src1).
- Undefined: all divides take XLEN+2 cycles; result values are identical in both builds.

Decomposition:
- Shared package: mul_div_op_t enum (8 funct3 codes), mul_div_state_t, XLEN and ROB index width constants (reuse rob_idx_t).
- Sub-module: mul_div_divider (iterative restoring core with start/done, magnitude inputs). Multiplier stays inline as a registered product plus a delay shift chain.

Test Plan:
- MUL 0xFFFFFFFF x 0xFFFFFFFF (MULHU) -> o_wb_data=0xFFFFFFFE at cycle 3 after accept; MUL low -> 0x00000001; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, at cycle 34; o_ready=0 throughout, rd/rob_idx echoed.
- DIVU 5 / 0 -> 0xFFFFFFFF; REM 0x80000000 / -1 -> 0; DIV same -> 0x80000000; latency 1 with MUL_DIV_UNIT_EARLY_OUT_EN, 34 without.
- Hold i_wb_ready=0 for 5 cycles in DONE -> o_wb_valid and data stable; i_wb_ready=1 -> o_ready=1 next cycle.
- i_flush at divide cycle 10 -> no writeback, o_ready=1 next cycle; a new MUL accepted then completes normally.
- Back-to-back ops with i_valid held high -> second accepted only when o_ready=1; no op lost or duplicated.
